// File: rtl/frac_norm_20.sv
// Two-stage normaliser: 20-bit magnitude plus leading-one position -> 16-bit fraction and 6-bit exponent.
// Define FRAC_NORM_ROUND_EN for round-to-nearest-even on right shifts; truncation otherwise.
module frac_norm_20 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] acc,
  input  logic [4:0]  lop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frac,
  output logic [5:0]  exp,
  output logic        zero,
  output logic        err
);

  logic s1_valid;
  logic s1_load;
  logic s2_load;

  logic [15:0] n_frac;
  logic [5:0]  n_exp;
  logic        n_zero;
  logic        n_err;

  logic [15:0] s1_frac;
  logic [5:0]  s1_exp;
  logic        s1_zero;
  logic        s1_err;

  logic [15:0] r_frac;
  logic [5:0]  r_exp;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Fixed slices for right shifts keep acc bits above lop-1 out of the result.
  always_comb begin
    n_frac = '0;
    n_exp  = '0;
    n_zero = 1'b0;
    n_err  = 1'b0;
    if (lop == 5'd0) begin
      n_zero = 1'b1;
    end else if (lop > 5'd20) begin
      n_zero = 1'b1;
      n_err  = 1'b1;
    end else begin
      n_exp = {1'b0, lop} - 6'd16;
      case (lop)
        5'd17:   n_frac = acc[16:1];
        5'd18:   n_frac = acc[17:2];
        5'd19:   n_frac = acc[18:3];
        5'd20:   n_frac = acc[19:4];
        default: n_frac = acc[15:0] << (5'd16 - lop);
      endcase
    end
  end

`ifdef FRAC_NORM_ROUND_EN
  logic        n_guard;
  logic        n_sticky;
  logic        s1_guard;
  logic        s1_sticky;
  logic        round_up;
  logic [16:0] sum;

  always_comb begin
    n_guard  = 1'b0;
    n_sticky = 1'b0;
    case (lop)
      5'd17: n_guard = acc[0];
      5'd18: begin n_guard = acc[1]; n_sticky = acc[0];    end
      5'd19: begin n_guard = acc[2]; n_sticky = |acc[1:0]; end
      5'd20: begin n_guard = acc[3]; n_sticky = |acc[2:0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (s1_load) begin
      s1_guard  <= n_guard;
      s1_sticky <= n_sticky;
    end
  end

  // Guard is zero for every non-right-shift case, so rounding needs no direction qualifier.
  always_comb begin
    round_up = s1_guard & (s1_sticky | s1_frac[0]);
    sum      = {1'b0, s1_frac} + {16'd0, round_up};
    r_frac   = sum[15:0];
    r_exp    = s1_exp;
    if (sum[16]) begin
      r_frac = 16'h8000;
      r_exp  = s1_exp + 6'd1;
    end
  end
`else
  always_comb begin
    r_frac = s1_frac;
    r_exp  = s1_exp;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_frac  <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_frac  <= n_frac;
      s1_exp   <= n_exp;
      s1_zero  <= n_zero;
      s1_err   <= n_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      frac      <= '0;
      exp       <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      frac      <= r_frac;
      exp       <= r_exp;
      zero      <= s1_zero;
      err       <= s1_err;
    end
  end

endmodule
